// File: rtl/rt_transmit_dev.sv
// rt_transmit_dev: MKIO / MIL-STD-1553 remote-terminal transmit-side message handler.
//
// On an accepted transmit command the block waits a fixed response gap, sends the status word
// and then streams N data words out of a local 32x16 buffer to the Manchester encoder through
// a ready/busy handshake. The host loads the buffer through an independent write port.
//
// Ports:
//   clk, reset            system clock, asynchronous active-high reset
//   start                 one-cycle pulse, cmd_word/cmd_perr valid
//   cmd_word, cmd_perr    decoded command word and its parity error flag
//   host_we/addr/data     buffer write port (usable at any time)
//   tx_data, tx_cd        word to encoder, 1 = command/status sync, 0 = data sync
//   tx_ready              word valid, held until the encoder raises tx_busy
//   tx_busy               encoder is transmitting
//   busy                  message in progress
//   done                  one-cycle pulse, message completed normally
//   timeout_err           one-cycle pulse, encoder never accepted a word
module rt_transmit_dev #(
    parameter logic [4:0]  ADDRESS    = 5'd1,
    parameter logic [7:0]  GAP_CYCLES = 8'd20,
    parameter logic [15:0] TIMEOUT    = 16'd4000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] cmd_word,
    input  logic        cmd_perr,
    input  logic        host_we,
    input  logic [4:0]  host_addr,
    input  logic [15:0] host_data,
    output logic [15:0] tx_data,
    output logic        tx_cd,
    output logic        tx_ready,
    input  logic        tx_busy,
    output logic        busy,
    output logic        done,
    output logic        timeout_err
);

    typedef enum logic [2:0] {
        StIdle,
        StGap,
        StLdStatus,
        StSend,
        StWaitDone,
        StRdMem,
        StLdData
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [5:0]  n_q, n_d;
    logic        mode_q, mode_d;
    logic [5:0]  wcnt_q, wcnt_d;
    logic [4:0]  rd_addr_q, rd_addr_d;
    logic [15:0] tx_data_q, tx_data_d;
    logic        tx_cd_q, tx_cd_d;
    logic        tx_ready_q, tx_ready_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        timeout_q, timeout_d;

    logic [15:0] mem [32];
    logic [15:0] rdata_q;

    logic        cmd_accept;
    logic        cmd_mode;
    logic [5:0]  cmd_n;

    // Buffer: read port free-runs on rd_addr_q. Non-blocking update of mem gives read-first
    // behaviour when the host writes the address being read in the same cycle.
    always_ff @(posedge clk) begin
        if (host_we) begin
            mem[host_addr] <= host_data;
        end
        rdata_q <= mem[rd_addr_q];
    end

    always_comb begin
        cmd_accept = start && !cmd_perr && (cmd_word[15:11] == ADDRESS) && cmd_word[10];
        cmd_mode   = (cmd_word[9:5] == 5'd0) || (cmd_word[9:5] == 5'd31);
        // A zero count field encodes 32 words: the MSB is set exactly when the field is zero.
        cmd_n      = {cmd_word[4:0] == 5'd0, cmd_word[4:0]};
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        n_d        = n_q;
        mode_d     = mode_q;
        wcnt_d     = wcnt_q;
        rd_addr_d  = rd_addr_q;
        tx_data_d  = tx_data_q;
        tx_cd_d    = tx_cd_q;
        tx_ready_d = tx_ready_q;
        done_d     = 1'b0;
        timeout_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                tx_ready_d = 1'b0;
                if (cmd_accept) begin
                    n_d       = cmd_n;
                    mode_d    = cmd_mode;
                    wcnt_d    = 6'd0;
                    rd_addr_d = 5'd0;
                    cnt_d     = 16'd0;
                    state_d   = StGap;
                end
            end
            StGap: begin
                if ((cnt_q + 16'd1) >= {8'd0, GAP_CYCLES}) begin
                    cnt_d   = 16'd0;
                    state_d = StLdStatus;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StLdStatus: begin
                tx_data_d  = {ADDRESS, 11'd0};
                tx_cd_d    = 1'b1;
                tx_ready_d = 1'b1;
                cnt_d      = 16'd0;
                state_d    = StSend;
            end
            StSend: begin
                if (tx_busy) begin
                    tx_ready_d = 1'b0;
                    state_d    = StWaitDone;
                end else if ((cnt_q + 16'd1) >= TIMEOUT) begin
                    tx_ready_d = 1'b0;
                    timeout_d  = 1'b1;
                    state_d    = StIdle;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StWaitDone: begin
                if (!tx_busy) begin
                    if (mode_q || (wcnt_q == n_q)) begin
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end else begin
                        state_d = StRdMem;
                    end
                end
            end
            StRdMem: begin
                // rd_addr_q has been stable on the read port since the last load, so the
                // buffer output is already valid and the word is loaded here directly; this
                // keeps data tx_ready two cycles after the previous tx_busy fall.
                tx_data_d  = rdata_q;
                tx_cd_d    = 1'b0;
                tx_ready_d = 1'b1;
                rd_addr_d  = rd_addr_q + 5'd1;
                wcnt_d     = wcnt_q + 6'd1;
                cnt_d      = 16'd0;
                state_d    = StSend;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            cnt_q      <= 16'd0;
            n_q        <= 6'd0;
            mode_q     <= 1'b0;
            wcnt_q     <= 6'd0;
            rd_addr_q  <= 5'd0;
            tx_data_q  <= 16'h0000;
            tx_cd_q    <= 1'b0;
            tx_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            n_q        <= n_d;
            mode_q     <= mode_d;
            wcnt_q     <= wcnt_d;
            rd_addr_q  <= rd_addr_d;
            tx_data_q  <= tx_data_d;
            tx_cd_q    <= tx_cd_d;
            tx_ready_q <= tx_ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            timeout_q  <= timeout_d;
        end
    end

    assign tx_data     = tx_data_q;
    assign tx_cd       = tx_cd_q;
    assign tx_ready    = tx_ready_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign timeout_err = timeout_q;

endmodule

// File: tb/tb_rt_transmit_dev.sv
// tb_rt_transmit_dev: scoreboard bench for rt_transmit_dev. The stimulus process pushes the
// expected word/done/timeout sequence of each command into a queue; a monitor pops and compares
// whenever the DUT presents a word, done or timeout_err. A simple encoder model drives tx_busy.
module tb_rt_transmit_dev;

    localparam logic [4:0] Addr = 5'd1;
    localparam int         Gap  = 20;
    localparam int         Tmo  = 200;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] cmd_word = 16'h0;
    logic        cmd_perr = 1'b0;
    logic        host_we = 1'b0;
    logic [4:0]  host_addr = 5'd0;
    logic [15:0] host_data = 16'h0;
    logic        tx_busy = 1'b0;
    logic [15:0] tx_data;
    logic        tx_cd;
    logic        tx_ready;
    logic        busy;
    logic        done;
    logic        timeout_err;

    rt_transmit_dev #(
        .ADDRESS    (Addr),
        .GAP_CYCLES (8'(Gap)),
        .TIMEOUT    (16'(Tmo))
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .cmd_word    (cmd_word),
        .cmd_perr    (cmd_perr),
        .host_we     (host_we),
        .host_addr   (host_addr),
        .host_data   (host_data),
        .tx_data     (tx_data),
        .tx_cd       (tx_cd),
        .tx_ready    (tx_ready),
        .tx_busy     (tx_busy),
        .busy        (busy),
        .done        (done),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    // kind: 0 = word, 1 = done, 2 = timeout
    typedef struct packed {
        logic [1:0]  kind;
        logic        cd;
        logic [15:0] data;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] mem_m [32];
    int          pass_cnt = 0;
    int          chk_cnt = 0;
    int          cyc = 0;
    int          start_cyc = 0;
    int          rdy_cyc = 0;
    int          last_fall = -100;
    int          data_seen = 0;
    bit          enc_en = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        chk_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    endtask

    // Encoder model: accepts a presented word after 0..3 cycles, transmits for 2..5 cycles.
    initial begin : encoder
        int d;
        forever begin
            @(negedge clk);
            if (reset) begin
                tx_busy = 1'b0;
            end else if (enc_en && tx_ready && !tx_busy) begin
                d = $urandom_range(0, 3);
                repeat (d) @(negedge clk);
                tx_busy = 1'b1;
                d = $urandom_range(2, 5);
                repeat (d) @(negedge clk);
                tx_busy   = 1'b0;
                last_fall = cyc;
            end
        end
    end

    initial begin : monitor
        exp_t e;
        logic rdy_prev;
        rdy_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                rdy_prev = 1'b0;
            end else begin
                if (tx_ready && !rdy_prev) begin
                    rdy_cyc = cyc;
                    check("word_expected", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("word_kind", 32'(e.kind), 32'd0);
                        check("word_value", {15'd0, tx_cd, tx_data}, {15'd0, e.cd, e.data});
                        check("busy_in_msg", 32'(busy), 32'd1);
                        if (e.cd) check("status_latency", 32'(rdy_cyc - start_cyc), 32'(Gap + 2));
                        else check("data_latency", 32'(rdy_cyc - last_fall), 32'd2);
                        if (!e.cd) data_seen++;
                    end
                end
                if (done) begin
                    check("done_expected", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("done_kind", 32'(e.kind), 32'd1);
                        check("done_busy_low", 32'(busy), 32'd0);
                        check("done_latency", 32'(cyc - last_fall), 32'd1);
                    end
                end
                if (timeout_err) begin
                    check("timeout_expected", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("timeout_kind", 32'(e.kind), 32'd2);
                        check("timeout_busy_low", 32'(busy), 32'd0);
                        check("timeout_latency", 32'(cyc - rdy_cyc), 32'(Tmo));
                    end
                end
                rdy_prev = tx_ready;
            end
        end
    end

    task automatic host_write(input int a, input logic [15:0] d);
        @(negedge clk);
        host_we   = 1'b1;
        host_addr = a[4:0];
        host_data = d;
        mem_m[a]  = d;
        @(negedge clk);
        host_we = 1'b0;
    endtask

    // Reference model: decode from the command rules and queue the whole expected message.
    task automatic send_cmd(input logic [15:0] c, input logic perr, input bit tmo);
        exp_t e;
        int   n;
        bit   acc;
        acc = !perr && (c[15:11] == Addr) && c[10];
        if (acc) begin
            e.kind = 2'd0; e.cd = 1'b1; e.data = {Addr, 11'd0};
            exp_q.push_back(e);
            if (tmo) begin
                e.kind = 2'd2; e.cd = 1'b0; e.data = 16'h0;
                exp_q.push_back(e);
            end else begin
                if (c[9:5] != 5'd0 && c[9:5] != 5'd31) begin
                    n = (c[4:0] == 5'd0) ? 32 : int'(c[4:0]);
                    for (int i = 0; i < n; i++) begin
                        e.kind = 2'd0; e.cd = 1'b0; e.data = mem_m[i];
                        exp_q.push_back(e);
                    end
                end
                e.kind = 2'd1; e.cd = 1'b0; e.data = 16'h0;
                exp_q.push_back(e);
            end
        end
        @(negedge clk);
        start     = 1'b1;
        cmd_word  = c;
        cmd_perr  = perr;
        start_cyc = cyc;
        @(negedge clk);
        start    = 1'b0;
        cmd_perr = 1'b0;
        check("busy_after_start", 32'(busy), 32'(acc));
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || busy) && k < 3000) begin
            @(negedge clk);
            k++;
        end
        check({name, "_complete"}, 32'(k < 3000), 32'd1);
        if (k >= 3000) exp_q.delete();
    endtask

    task automatic send_ignored(input string name, input logic [15:0] c, input logic perr);
        bit seen;
        send_cmd(c, perr, 1'b0);
        seen = 1'b0;
        repeat (Gap + 6) begin
            @(negedge clk);
            seen = seen | busy | tx_ready;
        end
        check({"ignored_", name}, 32'(seen), 32'd0);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [15:0] c;
        int          base;
        int          k;

        for (int i = 0; i < 32; i++) mem_m[i] = 16'h0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_outputs", 32'({tx_data, tx_cd, tx_ready, busy, done, timeout_err}), 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 32; i++) host_write(i, 16'h0);

        // Basic three-word message.
        host_write(0, 16'hA001);
        host_write(1, 16'hA002);
        host_write(2, 16'hA003);
        base = data_seen;
        send_cmd({5'd1, 1'b1, 5'd3, 5'd3}, 1'b0, 1'b0);
        wait_idle("three_words");
        check("three_words_count", 32'(data_seen - base), 32'd3);

        // Full 32-word message via count field 0.
        for (int i = 0; i < 32; i++) host_write(i, 16'($urandom));
        base = data_seen;
        send_cmd({Addr, 1'b1, 5'($urandom_range(1, 30)), 5'd0}, 1'b0, 1'b0);
        wait_idle("full_32");
        check("full_32_count", 32'(data_seen - base), 32'd32);

        // Commands that must be ignored.
        send_ignored("wrong_addr", {5'd2, 1'b1, 5'd3, 5'd3}, 1'b0);
        send_ignored("receive", {Addr, 1'b0, 5'd3, 5'd3}, 1'b0);
        send_ignored("parity", {Addr, 1'b1, 5'd3, 5'd3}, 1'b1);
        send_ignored("broadcast", {5'd31, 1'b1, 5'd3, 5'd3}, 1'b0);

        // Mode commands: status word only.
        base = data_seen;
        send_cmd({Addr, 1'b1, 5'd0, 5'd5}, 1'b0, 1'b0);
        wait_idle("mode_sa0");
        send_cmd({Addr, 1'b1, 5'd31, 5'd2}, 1'b0, 1'b0);
        wait_idle("mode_sa31");
        check("mode_no_data", 32'(data_seen - base), 32'd0);

        // Randomised messages with buffer updates between them.
        for (int m = 0; m < 5; m++) begin
            repeat (4) host_write($urandom_range(0, 31), 16'($urandom));
            c = {Addr, 1'b1, 5'($urandom_range(1, 30)), 5'($urandom)};
            send_cmd(c, 1'b0, 1'b0);
            wait_idle("random_msg");
        end

        // Encoder never accepts: timeout.
        enc_en = 1'b0;
        send_cmd({Addr, 1'b1, 5'd4, 5'd2}, 1'b0, 1'b1);
        wait_idle("timeout");
        check("timeout_idle_ready", 32'(tx_ready), 32'd0);
        enc_en = 1'b1;

        // Reset during the second data word, then a clean message.
        base = data_seen;
        send_cmd({Addr, 1'b1, 5'd2, 5'd5}, 1'b0, 1'b0);
        k = 0;
        while (data_seen < base + 2 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check("reached_second_word", 32'(k < 2000), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("midreset_outputs", 32'({tx_data, tx_cd, tx_ready, busy, done, timeout_err}),
              32'd0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        base = data_seen;
        send_cmd({Addr, 1'b1, 5'd6, 5'd4}, 1'b0, 1'b0);
        wait_idle("after_reset");
        check("after_reset_count", 32'(data_seen - base), 32'd4);

        repeat (5) @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
